// File: rtl/sort3_collector.sv
// sort3_collector: groups a valid/ready byte stream into A/B/C triplets for the
// three-input sorter, padding short frames, with a one-triplet collect buffer
// behind the output register so collection can continue while a triplet is held.
//
// state | meaning
// FILL0 | waiting for first beat of a triplet
// FILL1 | slot 0 filled, waiting for second beat
// FILL2 | slots 0..1 filled, waiting for third beat
// HOLD  | padded triplet parked in the slots, output register busy

module sort3_collector #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  PAD_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [1:0]       out_count,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {FILL0, FILL1, FILL2, HOLD} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] slot0, slot1, slot2;
    logic [1:0]       slot_count;
    logic [WIDTH-1:0] cand_a, cand_b, cand_c;
    logic [1:0]       cand_count;
    logic             fire, complete, load_ok, load_direct, load_held;

    // in_ready depends only on registered state, never on in_valid
    assign in_ready    = (state != HOLD);
    assign fire        = in_valid & in_ready;
    assign load_ok     = ~out_valid | out_ready;
    assign load_direct = complete & load_ok;
    assign load_held   = (state == HOLD) & load_ok;

    // Candidate triplet (earlier slots + current beat + padding) and completion
    always_comb begin
        cand_a     = slot0;
        cand_b     = PAD_VALUE;
        cand_c     = PAD_VALUE;
        cand_count = 2'd0;
        complete   = 1'b0;
        case (state)
            FILL0: begin
                cand_a     = in_data;
                cand_count = 2'd1;
                complete   = fire & in_last;
            end
            FILL1: begin
                cand_b     = in_data;
                cand_count = 2'd2;
                complete   = fire & in_last;
            end
            FILL2: begin
                cand_b     = slot1;
                cand_c     = in_data;
                cand_count = 2'd3;
                complete   = fire;
            end
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            FILL0:   if (complete) state_next = load_ok ? FILL0 : HOLD;
                     else if (fire) state_next = FILL1;
            FILL1:   if (complete) state_next = load_ok ? FILL0 : HOLD;
                     else if (fire) state_next = FILL2;
            FILL2:   if (complete) state_next = load_ok ? FILL0 : HOLD;
            HOLD:    if (load_ok) state_next = FILL0;
            default: state_next = FILL0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL0;
        else        state <= state_next;
    end

    // Collect slots: partial beats, or the whole padded triplet when parking in HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0      <= '0;
            slot1      <= '0;
            slot2      <= '0;
            slot_count <= 2'd0;
        end else if (complete && !load_ok) begin
            slot0      <= cand_a;
            slot1      <= cand_b;
            slot2      <= cand_c;
            slot_count <= cand_count;
        end else if (fire && !complete) begin
            if (state == FILL0) slot0 <= in_data;
            if (state == FILL1) slot1 <= in_data;
        end
    end

    // Output register: load direct or from the parked triplet, else retire on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_count <= 2'd0;
            out_valid <= 1'b0;
        end else if (load_direct) begin
            out_a     <= cand_a;
            out_b     <= cand_b;
            out_c     <= cand_c;
            out_count <= cand_count;
            out_valid <= 1'b1;
        end else if (load_held) begin
            out_a     <= slot0;
            out_b     <= slot1;
            out_c     <= slot2;
            out_count <= slot_count;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
